// File: rtl/tof_interval_meter.sv
// Time-of-flight interval meter: timestamps up to MAX_STOPS stop edges
// relative to one start edge and exposes the results over Avalon-MM.
module tof_interval_meter #(
  parameter int MAX_STOPS = 5,
  parameter int CNT_W     = 16
) (
  input  logic        avmm_clk,
  input  logic        avmm_reset_n,
  input  logic        avmm_cs,
  input  logic [2:0]  avmm_addr,
  input  logic        avmm_write,
  input  logic [31:0] avmm_writedata,
  input  logic        avmm_read,
  output logic [31:0] avmm_readdata,
  input  logic        start_pulse,
  input  logic        stop_pulse,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [2:0] MAX_CNT  = 3'(MAX_STOPS);
  localparam logic [2:0] LAST_IDX = 3'(MAX_STOPS - 1);

  logic [2:0]       start_sh, stop_sh;
  logic             start_edge, stop_edge;
  logic [1:0]       state;
  logic [CNT_W-1:0] counter, cnt_inc, timeout_reg, eff_timeout;
  logic [2:0]       stop_count, wr_ptr, rd_ptr, fifo_cnt;
  logic             overflow, done, irq_en, done_nxt, irq_en_nxt;
  logic [CNT_W-1:0] fifo_mem [MAX_STOPS];
  logic             bus_wr, bus_rd, arm, abort, push, pop, at_timeout, fifo_empty;
  logic [31:0]      rd_mux;

  // Two-flop synchronizers plus edge-detect stage; equal latency on both lines
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      start_sh <= '0;
      stop_sh  <= '0;
    end else begin
      start_sh <= {start_sh[1:0], start_pulse};
      stop_sh  <= {stop_sh[1:0], stop_pulse};
    end
  end

  // Bus decode, edge strobes, counter arithmetic and next-value logic
  always_comb begin
    start_edge  = start_sh[1] & ~start_sh[2];
    stop_edge   = stop_sh[1] & ~stop_sh[2];
    bus_wr      = avmm_cs & avmm_write;
    bus_rd      = avmm_cs & avmm_read & ~avmm_write;
    abort       = bus_wr && (avmm_addr == 3'd0) && avmm_writedata[1];
    arm         = bus_wr && (avmm_addr == 3'd0) && avmm_writedata[0] && !avmm_writedata[1];
    fifo_empty  = (fifo_cnt == 3'd0);
    pop         = bus_rd && (avmm_addr == 3'd3) && !fifo_empty;
    eff_timeout = (timeout_reg == '0) ? '1 : timeout_reg;
    // Captures use the post-increment value so a stop one cycle after start reads as 1
    cnt_inc     = (counter == '1) ? counter : counter + CNT_W'(1);
    at_timeout  = (state == ST_MEASURE) && (cnt_inc == eff_timeout);
    push        = (state == ST_MEASURE) && stop_edge && (stop_count < MAX_CNT) && !arm && !abort;
    irq_en_nxt  = (bus_wr && (avmm_addr == 3'd4)) ? avmm_writedata[0] : irq_en;
    done_nxt    = done;
    if (bus_wr && (avmm_addr == 3'd4) && avmm_writedata[1])
      done_nxt = 1'b0;
    if (arm)
      done_nxt = 1'b0;
    else if (!abort && at_timeout)
      done_nxt = 1'b1;
  end

  // Read-data multiplexer
  always_comb begin
    rd_mux = '0;
    case (avmm_addr)
      3'd1: rd_mux[7:0] = {fifo_empty, done, overflow, stop_count, state};
      3'd2: rd_mux[CNT_W-1:0] = timeout_reg;
      3'd3: begin
        if (!fifo_empty) begin
          rd_mux[31]        = 1'b1;
          rd_mux[CNT_W-1:0] = fifo_mem[rd_ptr];
        end
      end
      3'd4: rd_mux[0] = irq_en;
      default: rd_mux = '0;
    endcase
  end

  // Measurement state machine, capture bookkeeping and FIFO pointers
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      stop_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      if (pop) begin
        rd_ptr   <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 3'd1;
        fifo_cnt <= fifo_cnt - 3'd1;
      end
    end else if (arm) begin
      state      <= ST_ARMED;
      stop_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (start_edge) begin
            state   <= ST_MEASURE;
            counter <= '0;
          end
        end
        ST_MEASURE: begin
          counter <= cnt_inc;
          if (stop_edge) begin
            if (stop_count < MAX_CNT) stop_count <= stop_count + 3'd1;
            else                      overflow   <= 1'b1;
          end
          if (at_timeout) state <= ST_DONE;
        end
        default: state <= state;
      endcase
      if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 3'd1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Result storage; contents are only meaningful between the pointers
  always_ff @(posedge avmm_clk) begin
    if (push) fifo_mem[wr_ptr] <= cnt_inc;
  end

  // Registers, registered read data and interrupt
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      timeout_reg   <= '1;
      irq_en        <= 1'b0;
      done          <= 1'b0;
      avmm_readdata <= '0;
      irq           <= 1'b0;
    end else begin
      if (bus_wr && (avmm_addr == 3'd2)) timeout_reg <= avmm_writedata[CNT_W-1:0];
      irq_en <= irq_en_nxt;
      done   <= done_nxt;
      irq    <= done_nxt & irq_en_nxt;
      if (bus_rd) avmm_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_tof_interval_meter.sv
// Self-checking bench for tof_interval_meter with a list-based interval model.
module tb_tof_interval_meter;

  localparam int MAX_STOPS = 5;

  logic        avmm_clk = 1'b0;
  logic        avmm_reset_n;
  logic        avmm_cs;
  logic [2:0]  avmm_addr;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic        avmm_read;
  logic [31:0] avmm_readdata;
  logic        start_pulse;
  logic        stop_pulse;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int soffs[$];

  tof_interval_meter #(.MAX_STOPS(MAX_STOPS), .CNT_W(16)) dut (
    .avmm_clk(avmm_clk), .avmm_reset_n(avmm_reset_n), .avmm_cs(avmm_cs),
    .avmm_addr(avmm_addr), .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .avmm_read(avmm_read), .avmm_readdata(avmm_readdata),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .irq(irq)
  );

  always #5 avmm_clk = ~avmm_clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge avmm_clk);
    avmm_cs = 1'b1; avmm_write = 1'b1; avmm_addr = a; avmm_writedata = d;
    @(negedge avmm_clk);
    avmm_cs = 1'b0; avmm_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge avmm_clk);
    avmm_cs = 1'b1; avmm_read = 1'b1; avmm_addr = a;
    @(negedge avmm_clk);
    avmm_cs = 1'b0; avmm_read = 1'b0;
    d = avmm_readdata;
  endtask

  // Start pulses at cycles 0 and 3 (second one must be ignored); one-cycle
  // stop pulses at the sorted offsets in soffs; optional ABORT at abort_at.
  task automatic run_pulses(input int ncyc, input int abort_at);
    int idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge avmm_clk);
      start_pulse = (c == 0) || (c == 3);
      if (idx < soffs.size() && soffs[idx] == c) begin
        stop_pulse = 1'b1; idx++;
      end else stop_pulse = 1'b0;
      if (c == abort_at) begin
        avmm_cs = 1'b1; avmm_write = 1'b1; avmm_addr = 3'd0; avmm_writedata = 32'h2;
      end else if (c == abort_at + 1) begin
        avmm_cs = 1'b0; avmm_write = 1'b0;
      end
    end
    @(negedge avmm_clk);
    start_pulse = 1'b0; stop_pulse = 1'b0; avmm_cs = 1'b0; avmm_write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(negedge avmm_clk);
    checks++;
    if (avmm_readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: readdata=%h irq=%b, required 0/0", avmm_readdata, irq);
    end
    avmm_reset_n = 1'b1;
    bus_read(3'd1, d); checks++;
    if (d !== 32'h80) begin errors++; $display("FAIL reset_status: got %h required %h", d, 32'h80); end
    bus_read(3'd2, d); checks++;
    if (d !== 32'hFFFF) begin errors++; $display("FAIL reset_timeout: got %h required %h", d, 32'hFFFF); end
    bus_read(3'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_result: got %h required 0", d); end
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unused_addr: got %h required 0", d); end
  endtask

  // Scenarios 0..2 are the fixed basic/overflow/coincident cases, the rest random.
  task automatic test_intervals;
    logic [31:0] d, exp_st;
    int t, eff, ncyc, cur, n, ovf;
    int exp_q[$];
    for (int s = 0; s < 10; s++) begin
      soffs.delete();
      case (s)
        0: begin t = 1000; soffs.push_back(100); soffs.push_back(250); end
        1: begin t = 100; for (int k = 1; k <= 7; k++) soffs.push_back(10 * k); end
        2: begin t = 50; soffs.push_back(0); soffs.push_back(20); end
        default: begin
          t = $urandom_range(200, 30);
          n = $urandom_range(8, 0);
          cur = $urandom_range(3, 0);
          for (int k = 0; k < n; k++) begin
            soffs.push_back(cur);
            cur += $urandom_range(40, 2);
          end
        end
      endcase
      eff = (t == 0) ? 65535 : t;
      exp_q.delete(); ovf = 0;
      foreach (soffs[i]) begin
        if (soffs[i] >= 1 && soffs[i] <= eff) begin
          if (exp_q.size() < MAX_STOPS) exp_q.push_back(soffs[i]);
          else ovf = 1;
        end
      end
      ncyc = eff + 8;
      if (soffs.size() > 0 && soffs[soffs.size()-1] + 8 > ncyc) ncyc = soffs[soffs.size()-1] + 8;
      bus_write(3'd2, 32'(t));
      bus_write(3'd0, 32'h1);
      run_pulses(ncyc, -1);
      exp_st = 32'd3 | (32'(exp_q.size()) << 2) | (32'(ovf) << 5) | (32'd1 << 6)
             | ((exp_q.size() == 0) ? 32'h80 : 32'h0);
      bus_read(3'd1, d); checks++;
      if (d !== exp_st) begin
        errors++; $display("FAIL interval_status[%0d]: got %h required %h", s, d, exp_st);
      end
      foreach (exp_q[i]) begin
        bus_read(3'd3, d); checks++;
        if (d !== (32'h8000_0000 | 32'(exp_q[i]))) begin
          errors++; $display("FAIL interval_result[%0d.%0d]: got %h required %h",
                             s, i, d, 32'h8000_0000 | 32'(exp_q[i]));
        end
      end
      bus_read(3'd3, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL interval_drained[%0d]: got %h required 0", s, d); end
    end
  endtask

  task automatic test_timeout_boundary;
    logic [31:0] d;
    soffs.delete(); soffs.push_back(65535);
    bus_write(3'd2, 32'h0);
    bus_read(3'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL timeout_zero_rd: got %h required 0", d); end
    bus_write(3'd0, 32'h1);
    run_pulses(65541, -1);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h47) begin errors++; $display("FAIL boundary_status: got %h required %h", d, 32'h47); end
    bus_read(3'd3, d); checks++;
    if (d !== 32'h8000_FFFF) begin errors++; $display("FAIL boundary_result: got %h required %h", d, 32'h8000_FFFF); end
  endtask

  task automatic test_control;
    logic [31:0] d;
    bus_write(3'd2, 32'd1000);
    bus_write(3'd0, 32'h1);
    soffs.delete(); soffs.push_back(5); soffs.push_back(40);
    run_pulses(50, 20);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h04) begin errors++; $display("FAIL abort_status: got %h required %h", d, 32'h04); end
    bus_read(3'd3, d); checks++;
    if (d !== 32'h8000_0005) begin errors++; $display("FAIL abort_result: got %h required %h", d, 32'h8000_0005); end
    bus_read(3'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL abort_drained: got %h required 0", d); end
    bus_write(3'd0, 32'h1);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h81) begin errors++; $display("FAIL arm_status: got %h required %h", d, 32'h81); end
    bus_write(3'd0, 32'h3);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h80) begin errors++; $display("FAIL arm_abort_status: got %h required %h", d, 32'h80); end
    bus_write(3'd0, 32'h1);
    soffs.delete(); soffs.push_back(5);
    run_pulses(20, -1);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h06) begin errors++; $display("FAIL measure_status: got %h required %h", d, 32'h06); end
    bus_write(3'd0, 32'h1);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h81) begin errors++; $display("FAIL rearm_status: got %h required %h", d, 32'h81); end
    bus_write(3'd0, 32'h2);
  endtask

  task automatic test_irq_reset;
    logic [31:0] d;
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL irq_ctrl_rd: got %h required 1", d); end
    bus_write(3'd2, 32'd20);
    bus_write(3'd0, 32'h1);
    soffs.delete(); soffs.push_back(5);
    run_pulses(30, -1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
    bus_write(3'd4, 32'h3);
    @(negedge avmm_clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
    bus_read(3'd1, d); checks++;
    if (d !== 32'h07) begin errors++; $display("FAIL done_clear_status: got %h required %h", d, 32'h07); end
    bus_write(3'd2, 32'd500);
    bus_write(3'd0, 32'h1);
    soffs.delete();
    run_pulses(20, -1);
    bus_read(3'd1, d); checks++;
    if (d !== 32'h82) begin errors++; $display("FAIL pre_reset_status: got %h required %h", d, 32'h82); end
    #2 avmm_reset_n = 1'b0;
    #1;
    checks++;
    if (avmm_readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_reset: readdata=%h irq=%b, required 0/0", avmm_readdata, irq);
    end
    @(negedge avmm_clk);
    avmm_reset_n = 1'b1;
    bus_read(3'd2, d); checks++;
    if (d !== 32'hFFFF) begin errors++; $display("FAIL post_reset_timeout: got %h required %h", d, 32'hFFFF); end
    bus_read(3'd1, d); checks++;
    if (d !== 32'h80) begin errors++; $display("FAIL post_reset_status: got %h required %h", d, 32'h80); end
    bus_read(3'd4, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL post_reset_irq_en: got %h required 0", d); end
  endtask

  initial begin
    avmm_reset_n = 1'b0; avmm_cs = 1'b0; avmm_addr = '0; avmm_write = 1'b0;
    avmm_writedata = '0; avmm_read = 1'b0; start_pulse = 1'b0; stop_pulse = 1'b0;
    repeat (3) @(posedge avmm_clk);
    test_reset;
    test_intervals;
    test_timeout_boundary;
    test_control;
    test_irq_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tof_interval_meter.md
Name: tof_interval_meter

Overview:
- Time-of-flight interval meter. It consumes the start_pulse and stop_pulse lines from the test pulse generator or the real laser front-end.
- It timestamps up to MAX_STOPS stop rising edges relative to one start rising edge, in avmm_clk cycles.
- Results are buffered and read by the Nios over Avalon-MM. The irq line flags completion.

Parameters:
- MAX_STOPS, 5, depth of the result buffer (stop edges captured per measurement); 1..7
- CNT_W, 16, width of the interval counter and of each result

Ports:
- avmm_clk  in  1  system clock; all logic on its rising edge
- avmm_reset_n  in  1  asynchronous active-low reset
- avmm_cs  in  1  chip select
- avmm_addr  in  3  register address
- avmm_write  in  1  write strobe
- avmm_writedata  in  32  write data
- avmm_read  in  1  read strobe
- avmm_readdata  out  32  registered read data
- start_pulse  in  1  start line, treated as asynchronous
- stop_pulse  in  1  stop line (OR of echoes), treated as asynchronous
- irq  out  1  interrupt request, level

Behaviour:
- Reset, asynchronous while avmm_reset_n=0:
  - state=IDLE, counter=0, buffer empty, stop_count=0
  - overflow=0, done=0, irq_en=0, timeout=0xFFFF
  - avmm_readdata=0, irq=0, synchronizer flops=0
  - Reset mid-measurement discards everything.
- Input path: start_pulse and stop_pulse each go through a 2-flop synchronizer plus a rising-edge detector. Both have an identical 3-cycle latency, so the difference between the two edges is preserved.
- Register map:
  - addr 0 CONTROL (write): bit0 ARM, bit1 ABORT. Reads as 0.
  - addr 1 STATUS (read-only):
    - [1:0] state (0 IDLE, 1 ARMED, 2 MEASURE, 3 DONE)
    - [4:2] stop_count
    - [5] overflow
    - [6] done
    - [7] buffer empty
  - addr 2 TIMEOUT (read/write): [CNT_W-1:0]. A value of 0 is treated as 0xFFFF.
  - addr 3 RESULT (read pops the buffer): [31] valid, [CNT_W-1:0] interval. Reading an empty buffer returns 0 and pops nothing.
  - addr 4 IRQ_CTRL: bit0 irq_en (read/write). Writing bit1=1 clears done.
  - Addresses 5..7 read as 0; writes to them are ignored.
- Read timing: avmm_readdata is updated one cycle after avmm_cs&avmm_read; otherwise it holds its value. A write in the same cycle as a read takes priority, and the read is ignored.
- State machine:
  - IDLE: an ARM write goes to ARMED. It clears the buffer, stop_count, overflow and done.
  - ARMED:
    - A start edge goes to MEASURE; counter cleared to 0.
    - A stop edge is ignored, including one in the same cycle as the start edge.
  - MEASURE:
    - The counter increments every cycle and saturates at all-ones.
    - On each stop edge, if stop_count<MAX_STOPS, push the counter value and increment stop_count. Otherwise set overflow (sticky until the next ARM).
    - Further start edges are ignored.
    - When counter==effective timeout, go to DONE and set done. A stop edge in that same cycle is still captured.
  - DONE: holds until ARM (to ARMED, clearing as above) or ABORT (to IDLE).
  - ABORT from any state goes to IDLE. The buffer is kept and done is unchanged.
  - ARM and ABORT written together: ABORT wins.
  - ARM while in MEASURE or ARMED restarts: clear, then ARMED.
- Captured value: the number of avmm_clk cycles between the start and stop rising edges as sampled at the ports. A stop that is high on the cycle after start gives 1.
- Buffer behaviour:
  - It is a FIFO and pops in capture order.
  - A pop in the same cycle as a push is legal; both take effect.
  - A pop in the same cycle as an ARM is discarded, because ARM clears the buffer.
- irq = done & irq_en, registered.

Test Plan:
- Basic intervals: TIMEOUT=1000, ARM, start rises, stops at +100 and +250 → DONE at counter 1000, stop_count=2, done=1. RESULT reads return 0x80000064, 0x800000FA, then 0.
- Overflow: 7 stops at +10..+70 step 10 → 5 results (10..50), overflow=1, stop_count=5.
- Coincident edges: start and stop rise in the same cycle with ARMED → stop ignored. A later stop at +20 is captured as 20.
- Timeout boundary: TIMEOUT=0 with a stop at +65535 → stop captured as 0xFFFF, then DONE.
- Control priority: ABORT mid-MEASURE → state IDLE with no further captures. ARM+ABORT written together → IDLE. ARM during MEASURE → buffer empty, state ARMED.
- Interrupt and reset: irq_en=1 at DONE → irq=1, and writing IRQ_CTRL bit1 drops irq the next cycle. avmm_reset_n low mid-MEASURE → all outputs 0 immediately and TIMEOUT reads 0xFFFF.
